// File: rtl/draw_arbiter.sv
// Draw arbiter: grants one of four draw requesters the shared copy datapath.
// The stage background always wins. Tile and the two players share it round-robin.
// Each grant runs IDLE -> ACTIVE -> RELEASE. ACTIVE can be cut short by a timeout.
module draw_arbiter #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] req_sel,
    input  logic       finished,
    output logic [3:0] grant,
    output logic [1:0] memory_select,
    output logic       copy_enable,
    output logic       draw_stage,
    output logic       draw_t,
    output logic       draw_p1,
    output logic       draw_p2,
    output logic [3:0] done,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  msel_q, msel_d;
    logic [19:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;
    logic [1:0]  rr_q, rr_d;
    logic [3:0]  done_q, done_d;

    logic        win_valid;
    logic [1:0]  win_idx;
    logic [1:0]  cand1, cand2, cand3;

    // Next round-robin candidate after p, wrapping from 3 back to 1.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    // Winner selection: req[0] first, then a round-robin search over req[3:1].
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand1     = rr_next(rr_q);
        cand2     = rr_next(cand1);
        cand3     = rr_next(cand2);
        if (req[0]) begin
            win_valid = 1'b1;
            win_idx   = 2'd0;
        end else if (req[cand1]) begin
            win_valid = 1'b1;
            win_idx   = cand1;
        end else if (req[cand2]) begin
            win_valid = 1'b1;
            win_idx   = cand2;
        end else if (req[cand3]) begin
            win_valid = 1'b1;
            win_idx   = cand3;
        end
    end

    // Next-state logic. The held grant also selects which done bit is pulsed on release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        msel_d  = msel_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        rr_d    = rr_q;
        done_d  = 4'b0000;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ACTIVE;
                    grant_d = 4'b0001 << win_idx;
                    msel_d  = req_sel[{win_idx, 1'b0} +: 2];
                    cnt_d   = 20'd0;
                    // The priority requester does not move the round-robin pointer.
                    if (win_idx != 2'd0) begin
                        rr_d = win_idx;
                    end
                end
            end
            ACTIVE: begin
                if (finished) begin
                    state_d = RELEASE;
                    grant_d = 4'b0000;
                    msel_d  = 2'd0;
                    done_d  = grant_q;
                end else if (cnt_q == TIMEOUT_CYCLES - 20'd1) begin
                    state_d = RELEASE;
                    grant_d = 4'b0000;
                    msel_d  = 2'd0;
                    done_d  = grant_q;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset clears everything asynchronously and starts round-robin at req[1].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            msel_q  <= 2'd0;
            cnt_q   <= 20'd0;
            terr_q  <= 1'b0;
            rr_q    <= 2'd3;
            done_q  <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments make all registers update together from the old values.
            state_q <= state_d;
            grant_q <= grant_d;
            msel_q  <= msel_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
        end
    end

    assign grant         = grant_q;
    assign memory_select = msel_q;
    assign copy_enable   = (state_q == ACTIVE);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign timeout_err   = terr_q;
    assign draw_stage    = grant_q[0];
    assign draw_t        = grant_q[1];
    assign draw_p1       = grant_q[2];
    assign draw_p2       = grant_q[3];

endmodule
